// File: rtl/mem_io_pkg.sv
// Shared types and address-map offsets for the memory-mapped I/O controller.
// Register offsets below are counted down from OUT_BASE (the first output register).
package mem_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int OFS_OUT       = 0;
    localparam int OFS_KEY_EDGE  = 1;
    localparam int OFS_KEY_LEVEL = 2;
    localparam int OFS_SW        = 3;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchroniser with a registered previous value for falling-edge pulses.
// Edge pulses stay masked until the flops have settled after reset.
module input_sync #(
    parameter int WIDTH      = 1,
    parameter bit RESET_ONES = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [1:0]       settle_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q     <= {WIDTH{RESET_ONES}};
            sync_q     <= {WIDTH{RESET_ONES}};
            prev_q     <= {WIDTH{RESET_ONES}};
            settle_cnt <= 2'd3;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (settle_cnt != 2'd0)
                settle_cnt <= settle_cnt - 2'd1;
        end
    end

    assign sync_out = sync_q;
    assign fall     = (settle_cnt == 2'd0) ? (prev_q & ~sync_q) : '0;

endmodule

// File: rtl/mem_io_controller.sv
// Four-phase req/ack memory controller: block RAM plus memory-mapped output,
// switch, key-level and sticky key-press registers at the top of the address space.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for req; request fields latched when it arrives
//   ST_ACCESS | single read or write of the latched address, data_out loaded
//   ST_RESP   | ack held high until req drops
module mem_io_controller #(
    parameter int ADDRESS_BITS  = 16,
    parameter int MEMORY_BITS   = 16,
    parameter int NUM_OUT_PORTS = 6,
    parameter int SW_BITS       = 10,
    parameter int KEY_BITS      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req,
    input  logic                                 we,
    input  logic [ADDRESS_BITS-1:0]              addr,
    input  logic [MEMORY_BITS-1:0]               data_in,
    output logic [MEMORY_BITS-1:0]               data_out,
    output logic                                 ack,
    input  logic [SW_BITS-1:0]                   SW,
    input  logic [KEY_BITS-1:0]                  KEY,
    output logic [NUM_OUT_PORTS*MEMORY_BITS-1:0] port_out
);
    import mem_io_pkg::*;

    localparam int TOTAL      = 1 << ADDRESS_BITS;
    localparam int OUT_BASE_I = TOTAL - NUM_OUT_PORTS;
    localparam int RAM_WORDS  = OUT_BASE_I - OFS_SW;

    localparam logic [ADDRESS_BITS-1:0] OUT_BASE       = ADDRESS_BITS'(OUT_BASE_I);
    localparam logic [ADDRESS_BITS-1:0] ADDR_KEY_EDGE  = ADDRESS_BITS'(OUT_BASE_I - OFS_KEY_EDGE);
    localparam logic [ADDRESS_BITS-1:0] ADDR_KEY_LEVEL = ADDRESS_BITS'(OUT_BASE_I - OFS_KEY_LEVEL);
    localparam logic [ADDRESS_BITS-1:0] ADDR_SW        = ADDRESS_BITS'(OUT_BASE_I - OFS_SW);
    localparam logic [ADDRESS_BITS-1:0] RAM_END        = ADDRESS_BITS'(RAM_WORDS);

    state_t                              state;
    logic [ADDRESS_BITS-1:0]             addr_q;
    logic                                we_q;
    logic [MEMORY_BITS-1:0]              data_q;
    logic [MEMORY_BITS-1:0]              ram_q;
    logic [MEMORY_BITS-1:0]              rd_data;
    logic [MEMORY_BITS-1:0]              out_rd;
    logic [KEY_BITS-1:0]                 key_edge;
    logic [KEY_BITS-1:0]                 key_sync;
    logic [KEY_BITS-1:0]                 key_fall;
    logic [SW_BITS-1:0]                  sw_sync;
    logic [SW_BITS-1:0]                  sw_fall_unused;
    logic [NUM_OUT_PORTS*MEMORY_BITS-1:0] port_q;
    logic                                is_ram;

    input_sync #(.WIDTH(KEY_BITS), .RESET_ONES(1'b1)) u_key_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (KEY),
        .sync_out (key_sync),
        .fall     (key_fall)
    );

    input_sync #(.WIDTH(SW_BITS), .RESET_ONES(1'b0)) u_sw_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (SW),
        .sync_out (sw_sync),
        .fall     (sw_fall_unused)
    );

    (* ram_init_file = "RAM.mif" *) logic [MEMORY_BITS-1:0] mem [RAM_WORDS];

    // Read address is taken straight from addr in IDLE so the registered RAM
    // output is ready for the ACCESS cycle.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req)
            ram_q <= mem[addr];
        if (!reset && state == ST_ACCESS && we_q && is_ram)
            mem[addr_q] <= data_q;
    end

    assign is_ram = (addr_q < RAM_END);

    always_comb begin
        out_rd = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++)
            if (addr_q == OUT_BASE + ADDRESS_BITS'(OFS_OUT + i))
                out_rd = port_q[i*MEMORY_BITS +: MEMORY_BITS];
    end

    always_comb begin
        rd_data = out_rd;
        if (is_ram)
            rd_data = ram_q;
        else if (addr_q == ADDR_SW)
            rd_data = MEMORY_BITS'(sw_sync);
        else if (addr_q == ADDR_KEY_LEVEL)
            rd_data = MEMORY_BITS'(key_sync);
        else if (addr_q == ADDR_KEY_EDGE)
            rd_data = MEMORY_BITS'(key_edge);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ack      <= 1'b0;
            data_out <= '0;
            port_q   <= '0;
            key_edge <= '0;
        end else begin
            key_edge <= key_edge | key_fall;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q <= addr;
                        we_q   <= we;
                        data_q <= data_in;
                        state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (we_q) begin
                        for (int i = 0; i < NUM_OUT_PORTS; i++)
                            if (addr_q == OUT_BASE + ADDRESS_BITS'(OFS_OUT + i))
                                port_q[i*MEMORY_BITS +: MEMORY_BITS] <= data_q;
                    end else begin
                        data_out <= rd_data;
                        // Clear-on-read, but a press seen this cycle survives.
                        if (addr_q == ADDR_KEY_EDGE)
                            key_edge <= key_fall;
                    end
                    ack   <= 1'b1;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign port_out = port_q;

endmodule

// File: tb/tb_mem_io_controller.sv
// Directed plus randomized bench for mem_io_controller with an address-map reference model.
module tb_mem_io_controller;

    localparam int NP = 6;
    localparam int MB = 16;
    localparam logic [15:0] OUT_BASE    = 16'hFFFA;
    localparam logic [15:0] A_KEY_EDGE  = 16'hFFF9;
    localparam logic [15:0] A_KEY_LEVEL = 16'hFFF8;
    localparam logic [15:0] A_SW        = 16'hFFF7;
    localparam logic [15:0] RAM_TOP     = 16'hFFF6;

    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [15:0] addr, data_in;
    logic [15:0] data_out;
    logic        ack;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [95:0] port_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] ram_m [int];
    logic [15:0] out_m [NP];
    logic [3:0]  key_m, key_edge_m;
    logic [9:0]  sw_m;
    logic [15:0] dout_m;
    logic [15:0] rd;

    mem_io_controller dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .SW       (SW),
        .KEY      (KEY),
        .port_out (port_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] port_exp();
        logic [95:0] v;
        for (int i = 0; i < NP; i++)
            v[i*MB +: MB] = out_m[i];
        return v;
    endfunction

    task automatic set_keys(input logic [3:0] k);
        @(negedge clk);
        KEY = k;
        key_edge_m = key_edge_m | (key_m & ~k);
        key_m = k;
        repeat (4) @(posedge clk);
    endtask

    task automatic set_sw(input logic [9:0] v);
        @(negedge clk);
        SW = v;
        sw_m = v;
        repeat (4) @(posedge clk);
    endtask

    // One handshake; request fields are scrambled once latched.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input int hold, output logic [15:0] rdata);
        int lat;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; data_in = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                addr = 16'($urandom); data_in = 16'($urandom); we = ~w;
            end
        end while (!ack && lat < 8);
        check("ack_latency", 128'(lat), 128'(2));
        rdata = data_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("ack_hold", 128'(ack), 128'(1));
            check("dout_hold", 128'(data_out), 128'(rdata));
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        check("ack_fall", 128'(ack), 128'(0));
    endtask

    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d, input int hold);
        logic [15:0] exp, got;
        if (a <= RAM_TOP)          exp = ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'h0;
        else if (a >= OUT_BASE)    exp = out_m[int'(a - OUT_BASE)];
        else if (a == A_KEY_EDGE)  exp = {12'h0, key_edge_m};
        else if (a == A_KEY_LEVEL) exp = {12'h0, key_m};
        else                       exp = {6'h0, sw_m};
        access(w, a, d, hold, got);
        if (w) begin
            if (a <= RAM_TOP)       ram_m[int'(a)] = d;
            else if (a >= OUT_BASE) out_m[int'(a - OUT_BASE)] = d;
            exp = dout_m;
        end else begin
            dout_m = exp;
            if (a == A_KEY_EDGE) key_edge_m = '0;
        end
        check(w ? "dout_after_write" : "read_data", 128'(got), 128'(exp));
        check("port_out", 128'(port_out), 128'(port_exp()));
    endtask

    initial begin
        logic        w;
        logic [15:0] a, d;
        int          kind;

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        SW = '0; KEY = 4'b1110;
        sw_m = '0; key_m = 4'b1110; key_edge_m = '0; dout_m = '0;
        for (int i = 0; i < NP; i++) out_m[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 128'(ack), 128'(0));
        check("rst_dout", 128'(data_out), 128'(0));
        check("rst_port", 128'(port_out), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Key held low through reset must not register as a press.
        txn(1'b0, A_KEY_EDGE, 16'h0, 0);
        txn(1'b0, A_KEY_LEVEL, 16'h0, 0);
        set_keys(4'b1111);

        txn(1'b1, 16'h0010, 16'h1234, 0);
        txn(1'b0, 16'h0010, 16'h0, 0);
        check("ram_1234", 128'(dout_m), 128'(16'h1234));

        txn(1'b1, 16'hFFFD, 16'h007F, 2);
        check("port3_slice", 128'(port_out[63:48]), 128'(16'h007F));
        txn(1'b0, 16'hFFFD, 16'h0, 3);

        txn(1'b0, A_KEY_EDGE, 16'h0, 0);
        set_keys(4'b1101);
        set_keys(4'b1111);
        txn(1'b0, A_KEY_EDGE, 16'h0, 0);
        txn(1'b0, A_KEY_EDGE, 16'h0, 0);

        // Press lands in the ACCESS cycle of a KEY_EDGE read.
        @(negedge clk);
        KEY = 4'b1110;
        access(1'b0, A_KEY_EDGE, 16'h0, 0, rd);
        check("edge_race_read", 128'(rd), 128'(0));
        key_m = 4'b1110; key_edge_m = 4'b0001; dout_m = 16'h0;
        txn(1'b0, A_KEY_EDGE, 16'h0, 0);
        set_keys(4'b1111);

        set_sw(10'h2A5);
        txn(1'b1, A_SW, 16'hFFFF, 0);
        txn(1'b0, A_SW, 16'h0, 0);
        txn(1'b1, A_KEY_LEVEL, 16'h0000, 0);
        txn(1'b1, A_KEY_EDGE, 16'hFFFF, 0);
        txn(1'b1, RAM_TOP, 16'hBEEF, 0);
        txn(1'b0, RAM_TOP, 16'h0, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 3) set_sw(10'($urandom));
            if ($urandom_range(0, 9) < 3) set_keys(4'($urandom));
            kind = int'($urandom_range(0, 5));
            w = 1'($urandom);
            d = 16'($urandom);
            case (kind)
                0, 1:    a = ($urandom_range(0, 7) == 0) ? RAM_TOP : 16'($urandom_range(0, 63));
                2:       a = OUT_BASE + 16'($urandom_range(0, NP-1));
                3:       a = A_SW;
                4:       a = A_KEY_LEVEL;
                default: a = A_KEY_EDGE;
            endcase
            if (a <= RAM_TOP && !ram_m.exists(int'(a))) w = 1'b1;
            txn(w, a, d, int'($urandom_range(0, 2)));
        end

        // Reset during the ACCESS cycle of a RAM write.
        set_keys(4'b1111);
        txn(1'b1, 16'h0020, 16'h5A5A, 0);
        txn(1'b1, OUT_BASE + 16'd1, 16'h0055, 0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0020; data_in = 16'hDEAD;
        @(posedge clk); #1;
        check("pre_abort_ack", 128'(ack), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ack", 128'(ack), 128'(0));
        check("abort_port", 128'(port_out), 128'(0));
        check("abort_dout", 128'(data_out), 128'(0));
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        for (int i = 0; i < NP; i++) out_m[i] = '0;
        key_edge_m = '0; dout_m = '0;
        repeat (4) @(posedge clk);
        txn(1'b0, 16'h0020, 16'h0, 0);
        txn(1'b0, OUT_BASE + 16'd1, 16'h0, 0);
        txn(1'b0, A_KEY_EDGE, 16'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_controller.md
MEM_IO_CONTROLLER -- requirements
Module: mem_io_controller

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16: word-address width; TOTAL = 2**ADDRESS_BITS.
REQ-002 SHALL have parameter MEMORY_BITS, default 16: data word width.
REQ-003 SHALL have parameter NUM_OUT_PORTS, default 6, range 1..16: count of memory-mapped output registers.
REQ-004 SHALL have parameters SW_BITS, default 10, and KEY_BITS, default 4: input widths, each ≤ MEMORY_BITS.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req, input, 1: access request, four-phase handshake.
REQ-008 SHALL have port we, input, 1: 1 = write, 0 = read; sampled with req.
REQ-009 SHALL have port addr, input, ADDRESS_BITS: word address.
REQ-010 SHALL have port data_in, input, MEMORY_BITS: write data.
REQ-011 SHALL have port data_out, output, MEMORY_BITS: read data, valid while ack=1.
REQ-012 SHALL have port ack, output, 1: access complete.
REQ-013 SHALL have port SW, input, SW_BITS: asynchronous switches.
REQ-014 SHALL have port KEY, input, KEY_BITS: asynchronous pushbuttons, active-low.
REQ-015 SHALL have port port_out, output, NUM_OUT_PORTS*MEMORY_BITS: output registers; register i occupies bits [i*MEMORY_BITS +: MEMORY_BITS].

Function
REQ-016 SHALL decode addresses as follows: OUT_BASE = TOTAL-NUM_OUT_PORTS; out register i at OUT_BASE+i; KEY_EDGE at OUT_BASE-1; KEY_LEVEL at OUT_BASE-2; SW at OUT_BASE-3; RAM at 0..OUT_BASE-4.
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 SHALL, in IDLE with req=1, latch addr/we/data_in and go to ACCESS; with req=0, stay in IDLE.
REQ-019 SHALL, in ACCESS, perform exactly one access, load data_out, and go to RESP.
REQ-020 SHALL hold ack=1 throughout RESP and return to IDLE on the first cycle req=0 (ack falls that edge); ack first rises 2 cycles after req is sampled.
REQ-021 SHALL store data_in in RAM on RAM writes; data_out SHALL be the RAM word for RAM reads (synchronous read, inferred block RAM, contents initialised from RAM.mif, never reset).
REQ-022 SHALL update out register i on a write to it; reading it SHALL return its current value.
REQ-023 SHALL ignore writes to SW, KEY_LEVEL and KEY_EDGE; such writes still complete the handshake.
REQ-024 SHALL pass SW and KEY through two-flop synchronisers; reads of SW/KEY_LEVEL return synchronised values, zero-extended.
REQ-025 SHALL set KEY_EDGE bit k on a 1→0 transition of synchronised KEY[k] (press), sticky until cleared.
REQ-026 SHALL return KEY_EDGE zero-extended on read and clear it in the same ACCESS cycle; a press detected in that same cycle SHALL leave its bit set (set wins).
REQ-027 SHALL keep data_out unchanged outside ACCESS; writes SHALL leave data_out unchanged.
REQ-028 SHALL ignore changes on addr/we/data_in after latching.

Reset
REQ-029 SHALL, while reset=1 at a clock edge: state to IDLE; ack to 0; data_out to 0; all port_out to 0; KEY_EDGE to 0; KEY synchroniser flops to all ones; SW synchroniser flops to 0.
REQ-030 SHALL suppress any RAM or register write whose ACCESS edge coincides with reset=1; in-flight transactions are abandoned without ack.
REQ-031 SHALL not set KEY_EDGE from the synchroniser settling in the first two cycles after reset.

Structure
REQ-032 SHALL place the state enum and address-offset constants (OUT, KEY_EDGE, KEY_LEVEL, SW offsets) in package mem_io_pkg.
REQ-033 SHALL use one sub-module, input_sync, parameterised by width, implementing the two-flop synchroniser plus falling-edge pulse.

Verification
REQ-034 SHALL cover: write 0x1234 to RAM 0x0010, then read 0x0010 -> data_out=0x1234 with ack 2 cycles after req.
REQ-035 SHALL cover: write 0x007F to OUT_BASE+3 (0xFFFD) -> port_out[63:48]=0x007F, other ports 0; readback returns 0x007F.
REQ-036 SHALL cover: KEY=4'b1101, then 4'b1111, then read KEY_EDGE -> 0x0002; immediate re-read -> 0x0000.
REQ-037 SHALL cover: KEY[0] press timed to the KEY_EDGE read's ACCESS cycle -> read returns 0, bit 0 still set on the next read.
REQ-038 SHALL cover: req held high after ack -> ack held, no second access; req low -> IDLE next cycle.
REQ-039 SHALL cover: reset asserted in ACCESS of a write to 0x0020 -> RAM[0x0020] unchanged, ack=0, port_out=0.
